// File: rtl/adrv9009_tx_pkg.sv
// Shared definitions for the ADRV9009 TX interpolator chain: THB2 coefficients,
// default widths and the single-slot handshake FSM states.
package adrv9009_tx_pkg;

  localparam int THB2_DATA_W = 16;
  localparam int THB2_ACC_W  = 34;
  localparam int THB2_SHIFT  = 14;

  // Symmetric half of the 10-tap FIR phase; c9..c5 mirror c0..c4.
  localparam logic signed [15:0] THB2_C0 = 16'sd104;
  localparam logic signed [15:0] THB2_C1 = -16'sd406;
  localparam logic signed [15:0] THB2_C2 = 16'sd1120;
  localparam logic signed [15:0] THB2_C3 = -16'sd2802;
  localparam logic signed [15:0] THB2_C4 = 16'sd10188;

  typedef enum logic {
    TX_READY = 1'b0,
    TX_HOLD  = 1'b1
  } tx_hs_state_e;

  function automatic logic signed [15:0] thb2_coef(input int k);
    logic signed [15:0] c;
    case (k)
      0:       c = THB2_C0;
      1:       c = THB2_C1;
      2:       c = THB2_C2;
      3:       c = THB2_C3;
      default: c = THB2_C4;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adrv9009_round_sat.sv
// Combinational arithmetic right shift with round-half-up and saturation to OUT_W bits.
module adrv9009_round_sat #(
  parameter int IN_W  = 34,
  parameter int SHIFT = 14,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_acc,
  output logic signed [OUT_W-1:0] o_y
);

  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (OUT_W - 1)));

  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_shr;

  always_comb begin
    w_rnd = RW'(i_acc) + HALF;
    w_shr = w_rnd >>> SHIFT;
    if (w_shr > MAXV) begin
      o_y = OUT_W'(MAXV);
    end else if (w_shr < MINV) begin
      o_y = OUT_W'(MINV);
    end else begin
      o_y = OUT_W'(w_shr);
    end
  end

endmodule

// File: rtl/adrv9009_thb2.sv
// TX half-band 2x interpolator: one input per two cycles, emits FIR phase at k+4
// and the center-tap phase (x[m-4] passed through) at k+5.
module adrv9009_thb2
  import adrv9009_tx_pkg::*;
#(
  parameter int DATA_W = THB2_DATA_W,
  parameter int ACC_W  = THB2_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     out_phase,
  output tx_hs_state_e             o_dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on FSM state and reset, never on in_valid.

  localparam int PW = 2 * DATA_W + 1;

  tx_hs_state_e r_state;
  tx_hs_state_e w_next;
  logic         w_ready;
  logic         w_accept;

  logic signed [DATA_W-1:0] r_x   [10];
  logic signed [DATA_W:0]   r_p   [5];
  logic signed [PW-1:0]     r_m   [5];
  logic signed [DATA_W-1:0] r_ctr [4];
  logic signed [ACC_W-1:0]  r_s0;
  logic signed [ACC_W-1:0]  r_s1;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [DATA_W-1:0] w_even;
  logic                     r_v0, r_v1, r_v2, r_v3, r_v4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= TX_READY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      TX_READY: begin
        w_ready = 1'b1;
        if (in_valid) w_next = TX_HOLD;
      end
      default: w_next = TX_READY;
    endcase
  end

  assign in_ready    = w_ready & ~reset;
  assign w_accept    = in_valid & in_ready;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) r_x[i] <= '0;
    end else if (w_accept) begin
      r_x[0] <= in;
      for (int i = 1; i < 10; i++) r_x[i] <= r_x[i-1];
    end
  end

  // Datapath runs every cycle; the r_v* tokens mark which results are real.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 5; k++) begin
        r_p[k] <= '0;
        r_m[k] <= '0;
      end
      for (int i = 0; i < 4; i++) r_ctr[i] <= '0;
      r_s0 <= '0;
      r_s1 <= '0;
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        r_p[k] <= (DATA_W + 1)'(r_x[k]) + (DATA_W + 1)'(r_x[9-k]);
        r_m[k] <= PW'(r_p[k]) * PW'(thb2_coef(k));
      end
      r_s0     <= ACC_W'(r_m[0]) + ACC_W'(r_m[1]) + ACC_W'(r_m[2]);
      r_s1     <= ACC_W'(r_m[3]) + ACC_W'(r_m[4]);
      r_ctr[0] <= r_x[4];
      for (int i = 1; i < 4; i++) r_ctr[i] <= r_ctr[i-1];
      r_v0 <= w_accept;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
    end
  end

  assign w_acc = r_s0 + r_s1;

  adrv9009_round_sat #(
    .IN_W (ACC_W),
    .SHIFT(THB2_SHIFT),
    .OUT_W(DATA_W)
  ) u_round_sat (
    .i_acc(w_acc),
    .o_y  (w_even)
  );

  // Input spacing of two cycles guarantees r_v3 and r_v4 are never both set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_phase <= 1'b0;
    end else if (r_v3) begin
      out       <= w_even;
      out_valid <= 1'b1;
      out_phase <= 1'b0;
    end else if (r_v4) begin
      out       <= r_ctr[3];
      out_valid <= 1'b1;
      out_phase <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adrv9009_thb2.sv
// Bench for adrv9009_thb2: direct 10-tap convolution model with timed expected queue.
module tb_adrv9009_thb2;
  import adrv9009_tx_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] in_s = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] out_s;
  logic               out_valid;
  logic               out_phase;
  tx_hs_state_e       dbg_state;

  localparam int COEF[10] = '{104, -406, 1120, -2802, 10188, 10188, -2802, 1120, -406, 104};

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hist[10];

  logic [15:0] exp_q[$];
  logic        exp_ph_q[$];
  int          exp_due_q[$];

  logic [15:0] e_val;
  logic        e_ph;
  int          e_due;
  logic        prev_rdy;

  adrv9009_thb2 dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in_s),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out_s),
    .out_valid  (out_valid),
    .out_phase  (out_phase),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: on each accepted sample, convolve the full history
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) hist[i] = 0;
      exp_q.delete();
      exp_ph_q.delete();
      exp_due_q.delete();
    end else begin
      cyc++;
      if (in_valid && in_ready) begin
        longint acc;
        longint y;
        for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(in_s);
        acc = 0;
        for (int i = 0; i < 10; i++) acc += longint'(COEF[i]) * longint'(hist[i]);
        y = (acc + 8192) >>> 14;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        exp_q.push_back(16'(y));
        exp_ph_q.push_back(1'b0);
        exp_due_q.push_back(cyc + 4);
        exp_q.push_back(16'(hist[4]));
        exp_ph_q.push_back(1'b1);
        exp_due_q.push_back(cyc + 5);
      end
    end
  end

  // scoreboard: every out_valid must match the front of the expected queue
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e_val = exp_q.pop_front();
        e_ph  = exp_ph_q.pop_front();
        e_due = exp_due_q.pop_front();
        chk("out_value", longint'(out_s), longint'($signed(e_val)));
        chk("out_phase", out_phase, e_ph);
        chk("out_time", cyc, e_due);
      end
    end else if (exp_due_q.size() > 0 && exp_due_q[0] <= cyc) begin
      chk("missing_valid", 0, 1);
      void'(exp_q.pop_front());
      void'(exp_ph_q.pop_front());
      void'(exp_due_q.pop_front());
    end
  end

  // driver tasks
  task automatic send(input logic signed [15:0] v);
    int t = 0;
    in_s     = v;
    in_valid = 1'b1;
    while (!in_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic impulse_burst(input int max_gap);
    send(16'sd16384);
    if (max_gap > 0) idle($urandom_range(max_gap, 2));
    for (int i = 0; i < 11; i++) begin
      send(16'sd0);
      if (max_gap > 0) idle($urandom_range(max_gap, 2));
    end
    idle(10);
  endtask

  initial begin
    // reset held 3 cycles with in_valid high
    reset    = 1'b1;
    in_valid = 1'b1;
    in_s     = 16'sd16384;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", longint'(out_s), 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);
    chk("state_after_rst", dbg_state, TX_READY);
    @(negedge clk);

    // impulse, back-to-back
    impulse_burst(0);

    // DC saturation, both rails
    for (int i = 0; i < 12; i++) send(16'sd32767);
    for (int i = 0; i < 12; i++) send(-16'sd32768);
    idle(10);

    // in_valid held high: in_ready must toggle every cycle
    in_valid = 1'b1;
    in_s     = 16'($urandom);
    @(negedge clk);
    prev_rdy = in_ready;
    for (int i = 0; i < 30; i++) begin
      in_s = 16'($urandom);
      @(negedge clk);
      chk("ready_toggle", in_ready, !prev_rdy);
      prev_rdy = in_ready;
    end
    in_valid = 1'b0;
    idle(10);

    // impulse with random 2..7 cycle gaps
    impulse_burst(7);

    // random samples with random gaps
    for (int i = 0; i < 30; i++) begin
      send(16'($urandom));
      idle($urandom_range(3, 0));
    end
    idle(10);

    // mid-burst asynchronous reset, then fresh data on zero history
    send(16'sd16384);
    send(16'sd0);
    send(16'sd0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_out", longint'(out_s), 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    idle(2);
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", in_ready, 1);
    idle(3);
    send(16'sd1000);
    for (int i = 0; i < 11; i++) send(16'sd0);
    idle(10);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adrv9009_thb2.md
# adrv9009_thb2

Transmit half-band interpolator, stage 2: 2x interpolating half-band FIR in the ADRV9009 TX signal path, mirroring the receive RHB2 stage and sharing its coefficient set. Accepts one 16-bit sample per handshake and emits two output samples in consecutive cycles. The first is the polyphase FIR phase and the second is the center-tap phase. Unity passband gain, Q1.15 in and out, rounding and saturation on the output.

## Interface
- `DATA_W`, 16: input/output sample width (signed Q1.15); fixed at 16 in this revision.
- `ACC_W`, 34: accumulator width for the FIR phase.
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-high reset.
- `in` input 16: signed input sample.
- `in_valid` input 1: `in` holds a sample.
- `in_ready` output 1: block can accept a sample this cycle.
- `out` output 16: signed interpolated output sample, registered.
- `out_valid` output 1: `out` holds a sample this cycle.
- `out_phase` output 1: 0 = FIR (even) sample, 1 = center-tap (odd) sample; meaningful only while `out_valid`.

## Operation
- Coefficients c0..c9 are applied to x[m]..x[m-9] and equal 2× the RX half-band even taps in Q1.15: 104, -406, 1120, -2802, 10188, 10188, -2802, 1120, -406, 104. The sum is 16408.
- Acceptance is `in_valid && in_ready` at a rising edge. On acceptance, the 10-deep delay line shifts (x[m] enters), and only then. Gaps between inputs are allowed and leave filter state untouched.
- Handshake FSM:
  - READY: `in_ready`=1. Acceptance moves the FSM to HOLD; otherwise it stays in READY.
  - HOLD: `in_ready`=0. Moves unconditionally to READY.
  - Minimum input spacing is therefore 2 cycles. `in_ready` never depends combinationally on `in_valid`.
- FIR phase computation:
  - Symmetric pre-add p_k = x[m-k] + x[m-9+k] for k=0..4, 17-bit.
  - Products c_k·p_k, 33-bit.
  - Adder tree into `ACC_W` bits.
  - Result y_even = sat16((acc + 2^13) >>> 14): round half up, then clamp to [-32768, 32767].
- Center-tap phase: y_odd = x[m-4], passed through exactly (0.5 × 2 gain) with no arithmetic.
- No output backpressure. Each accepted sample always produces exactly one even/odd pair.

## Timing
- Acceptance at edge k. Pipeline stages:
  - Edge k+1: pre-add registers.
  - Edge k+2: product registers.
  - Edge k+3: partial sums, 3 + 2 terms.
  - Edge k+4: final sum, round and saturate into `out`, with `out_valid`=1 and `out_phase`=0.
  - Edge k+5: `out` = x[m-4] from a 4-stage aligned copy, `out_valid`=1, `out_phase`=1.
- Output latency is 4 cycles to the even sample and 5 to the odd sample. With back-to-back inputs every 2 cycles, `out_valid` stays continuously high and `out_phase` toggles 0,1,0,1.
- When no output is due, `out_valid`=0 and `out` holds its last value.
- Reset values, asserted immediately on reset:
  - `out`=0, `out_valid`=0, `out_phase`=0.
  - `in_ready`=0 while reset is high, then 1 in the first cycle after reset is released.
  - FSM in READY.
  - Delay line, pipeline registers and valid tokens all cleared.
- Reset mid-burst: in-flight outputs are discarded, with no `out_valid` after release until new data is accepted. The new data sees a zero history.

## Structure
- Package `adrv9009_tx_pkg` holds:
  - THB2 coefficient localparams c0..c4 (symmetric half only).
  - `DATA_W` and `ACC_W` defaults.
  - The FSM state enum (READY, HOLD), reusable by later TX stages (THB1, TFIR).
- One sub-module, `adrv9009_round_sat`, performs the arithmetic right shift by a parameterized amount with round-half-up and saturation to 16 bits. It is purely combinational and registered by the caller.

## Test plan
- Reset: hold `reset` for 3 cycles with `in_valid`=1. Required: `out`=0, `out_valid`=0, `in_ready`=0 throughout; `in_ready`=1 on the first cycle after release.
- Impulse: accept 16384 followed by 11 zeros, one every 2 cycles.
  - Even outputs are 104, -406, 1120, -2802, 10188, 10188, -2802, 1120, -406, 104, 0.
  - Odd outputs are 0, 0, 0, 0, 16384, 0, …
  - The first even sample appears exactly 4 cycles after acceptance.
- Saturation: steady DC 32767 gives even 32767 (clamped from 32815) and odd 32767. Steady DC -32768 gives even -32768 (clamped from -32816) and odd -32768.
- Handshake: `in_valid` held high continuously.
  - `in_ready` toggles 1,0.
  - One acceptance every 2 cycles.
  - After fill, `out_valid` stays high with `out_phase` alternating 0,1.
- Gapped input: repeat the impulse test with random 2–7 cycle gaps. Output values must match the impulse test, each pair arriving at k+4/k+5, with `out_valid`=0 in the gaps.
- Mid-burst reset: assert `reset` asynchronously after 3 impulse-test samples, then apply 1000 followed by zeros. Required: no output until k+4, and even outputs equal round(1000·c_k/16384) with no contribution from the pre-reset samples.
